pwr_test_sequencer: RTL and testbench
=====================================

// Module: pwr_test_sequencer
// PURPOSE
//  Clocked controller for the adder power-estimation setup. It clears the transition-counter
//  memory, then drives operand pairs into the adders under test with a fixed settle time per pair.
//  At the end it reads back every counter through a valid/ready stream.
//  It replaces the hand-timed initial block of the bench and sits between the bench top, the adders and memTrans.
// PARAMETERS
//  NUM_CNTR    3        number of transition counters (addresses 0..NUM_CNTR-1)
//  DIR_W       2        memory address width; 2**DIR_W >= NUM_CNTR
//  DATA_W      32       counter word width
//  N_SUMS      5000     operand pairs applied per run (>=1)
//  SETTLE_CYC  50       cycles each pair is held; also the final drain time (>=1)
//  LFSR_SEED   16'hACE1 LFSR reset/start value, must be nonzero
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       one-cycle pulse; accepted only in IDLE or DONE
//  busy        out  1       high from start acceptance until DONE
//  done        out  1       high in DONE until next accepted start or reset
//  opr_a       out  8       operand A to all adders
//  opr_b       out  8       operand B to all adders
//  sum_idx     out  clog2(N_SUMS+1)  number of pairs applied so far
//  mem_dir     out  DIR_W   counter memory address
//  mem_le      out  1       1 = read / hold, 0 = write mem_wdata at mem_dir
//  mem_wdata   out  DATA_W  write data; the bench wrapper tristates it onto dato when mem_le=0
//  mem_rdata   in   DATA_W  memory read data (dato when mem_le=1)
//  rd_valid    out  1       rd_index/rd_count are valid
//  rd_ready    in   1       consumer accepts the word
//  rd_index    out  DIR_W   counter address of the presented word
//  rd_count    out  DATA_W  captured counter value
// BEHAVIOUR
//  Reset (sync, active high): state=IDLE, mem_le=1, mem_dir=0, mem_wdata=0, opr_a=opr_b=0,
//   sum_idx=0, busy=done=rd_valid=0, rd_index=0, rd_count=0, lfsr=LFSR_SEED.
//   Reset mid-run aborts immediately. Memory contents are left as they are. There are no partial writes
//   because mem_le is registered high in the reset cycle.
//  FSM: IDLE -> CLEAR -> RUN -> DRAIN -> RD_ADDR <-> RD_WAIT -> DONE. DONE -> CLEAR on start.
//  IDLE/DONE: mem_le=1. A start pulse moves to CLEAR next cycle and sets busy=1, done=0. start is ignored in all other states.
//  CLEAR: mem_le=0, mem_wdata=0, mem_dir steps 0..NUM_CNTR-1, one cycle each (NUM_CNTR cycles).
//   Then mem_le=1, lfsr reloads LFSR_SEED, and the FSM moves to RUN.
//  RUN: the first pair is fixed at opr_a=8'h01, opr_b=8'hFF (worst-case ripple) and sum_idx becomes 1.
//   Each pair is held exactly SETTLE_CYC cycles. The next pair is applied in the same edge that the hold ends.
//   For each later pair the LFSR advances one step (x^16+x^14+x^13+x^11+1, Fibonacci, shift left).
//   The pair is opr_a=lfsr_next[15:8], opr_b=lfsr_next[7:0], and sum_idx increments.
//   After pair N_SUMS has been held SETTLE_CYC cycles, the FSM goes to DRAIN. Operands stay unchanged.
//  DRAIN: SETTLE_CYC idle cycles so in-flight gate transitions are counted, then the FSM goes to RD_ADDR with index 0.
//  RD_ADDR: mem_le=1 and mem_dir=index for one cycle.
//  RD_WAIT: rd_count<=mem_rdata and rd_index<=index are registered on entry, and rd_valid=1.
//   rd_valid, rd_count and rd_index stay stable until rd_valid&&rd_ready.
//   On that handshake rd_valid drops. The FSM goes to RD_ADDR for the next index, or to DONE after index NUM_CNTR-1.
//   With rd_ready tied high, words arrive every 2 cycles.
//  Operands hold their last value in DRAIN, RD_* and DONE. mem_wdata=0 and mem_le=1 outside CLEAR.
//  Boundaries:
//   - N_SUMS=1: only the fixed pair is applied; sum_idx ends at 1.
//   - NUM_CNTR=1: CLEAR takes 1 cycle and a single word is read.
//   - The LFSR never reaches zero; a zero state is an assertion failure.
//   - rd_ready high in the cycle before rd_valid has no effect.
// STRUCTURE
//  Include file pwr_seq_defs.vh holds:
//   - state encodings (localparams)
//   - LFSR tap mask 16'hB400
//   - first-pair constants 8'h01 / 8'hFF
//   - default NUM_CNTR/DIR_W matching `NumPwrCntr/`Ndir
//  One sub-module, pwr_lfsr16 (load, step, seed -> q, q_next), instantiated once.
//  The FSM, settle counter, sum counter and readout registers live in the top module.
// TESTING
//  1 reset then start, NUM_CNTR=3, memory preloaded 7,8,9 -> CLEAR writes 0 to dir 0,1,2 on consecutive cycles;
//    readback gives (0,0),(1,0),(2,0).
//  2 N_SUMS=3, SETTLE_CYC=4 -> opr 01/FF for 4 cycles, then two LFSR pairs from seed ACE1 matching the model;
//    DRAIN lasts 4 cycles; done asserts with sum_idx=3.
//  3 rd_ready held low 10 cycles on word 1 -> rd_valid/rd_index=1/rd_count stable throughout; no skip or duplicate.
//  4 reset asserted in the 2nd cycle of RUN -> next cycle IDLE, all outputs at reset values, memory untouched.
//  5 start pulsed during RUN and RD_WAIT -> ignored; start in DONE -> new CLEAR, done=0, busy=1.
//  6 full bench with the three adders, N_SUMS=5000 -> rd_count for counter 0/1/2 nonzero and equal to the
//    totals accumulated by the gate models.

Source files
------------

// File: rtl/pwr_test_sequencer_pkg.sv
// Shared definitions for the adder power-estimation sequencer.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, LFSR feedback mask and step function,
// the fixed worst-case first operand pair, and default counter geometry.
package pwr_test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    // Feedback taps for x^16+x^14+x^13+x^11+1: bits 15,13,12,10 of the state.
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    // 0x01 + 0xFF ripples a carry through every bit position of the adders.
    localparam logic [7:0] FIRST_OPR_A = 8'h01;
    localparam logic [7:0] FIRST_OPR_B = 8'hFF;

    // Default geometry of the transition-counter memory.
    localparam int DEF_NUM_CNTR = 3;
    localparam int DEF_DIR_W    = 2;

    // Fibonacci step, shifting left: feedback enters at bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/pwr_test_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR generating pseudo-random operand pairs.
// Latency: q updates one cycle after load/step; q_next is combinational.
// Backpressure: none; advances only when step is high.
//
// Ports: clk, reset (sync, active high, loads seed); load (reload seed);
// step (advance one state); seed (start value); q (current state);
// q_next (state after one step).
module pwr_lfsr16
    import pwr_test_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q,
    output logic [15:0] q_next
);

    assign q_next = lfsr16_next(q);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            q <= seed;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/pwr_test_sequencer.sv
// Sequencer for adder power estimation: clear counters, apply operand pairs, read counters back.
// Latency: start -> first clear write 1 cycle; each pair held SETTLE_CYC cycles; one word per 2 cycles.
// Backpressure: rd_valid/rd_count/rd_index hold until rd_ready; all other outputs are free-running.
//
// Ports: clk, reset (sync, active high); start (pulse, honoured in IDLE/DONE);
// busy/done (run status); opr_a/opr_b (operands to the adders); sum_idx (pairs applied);
// mem_dir/mem_le/mem_wdata/mem_rdata (counter memory port, mem_le=0 writes);
// rd_valid/rd_ready/rd_index/rd_count (counter readout stream).
module pwr_test_sequencer
    import pwr_test_sequencer_pkg::*;
#(
    parameter int          NUM_CNTR   = DEF_NUM_CNTR,
    parameter int          DIR_W      = DEF_DIR_W,
    parameter int          DATA_W     = 32,
    parameter int          N_SUMS     = 5000,
    parameter int          SETTLE_CYC = 50,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    opr_a,
    output logic [7:0]                    opr_b,
    output logic [$clog2(N_SUMS+1)-1:0]   sum_idx,
    output logic [DIR_W-1:0]              mem_dir,
    output logic                          mem_le,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DIR_W-1:0]              rd_index,
    output logic [DATA_W-1:0]             rd_count
);

    localparam int SUM_W = $clog2(N_SUMS + 1);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    localparam logic [SUM_W-1:0] LAST_SUM    = SUM_W'(N_SUMS);
    localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYC - 1);
    localparam logic [DIR_W-1:0] LAST_CNTR   = DIR_W'(NUM_CNTR - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [DIR_W-1:0] idx;          // clear address, then readout index
    logic             settle_end;
    logic             last_sum;
    logic             last_cntr;
    logic             lfsr_load;
    logic             lfsr_step;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_q_next;

    assign settle_end = (settle_cnt == LAST_SETTLE);
    assign last_sum   = (sum_idx == LAST_SUM);
    assign last_cntr  = (idx == LAST_CNTR);

    // Counters are only ever cleared, so the write data is constant zero.
    assign mem_wdata = '0;

    pwr_lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (lfsr_load),
        .step   (lfsr_step),
        .seed   (LFSR_SEED),
        .q      (lfsr_q),
        .q_next (lfsr_q_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:         if (last_cntr) state_nxt = ST_RUN;
            ST_RUN:           if (settle_end && last_sum) state_nxt = ST_DRAIN;
            ST_DRAIN:         if (settle_end) state_nxt = ST_RD_ADDR;
            ST_RD_ADDR:       state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:       if (rd_ready) state_nxt = last_cntr ? ST_DONE : ST_RD_ADDR;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: LFSR control strobes
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (state == ST_CLEAR && last_cntr) begin
            lfsr_load = 1'b1;
        end
        if (state == ST_RUN && settle_end && !last_sum) begin
            lfsr_step = 1'b1;
        end
    end

    // Registered outputs, settle counter and readout registers
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            opr_a      <= '0;
            opr_b      <= '0;
            sum_idx    <= '0;
            mem_dir    <= '0;
            mem_le     <= 1'b1;
            rd_valid   <= 1'b0;
            rd_index   <= '0;
            rd_count   <= '0;
        end else begin
            // One counter times both the per-pair hold and the drain window.
            if ((state == ST_RUN || state == ST_DRAIN) && !settle_end) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end else begin
                settle_cnt <= '0;
            end

            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        mem_le  <= 1'b0;
                        mem_dir <= '0;
                        idx     <= '0;
                        sum_idx <= '0;   // a new run has applied no pairs yet
                    end
                end
                ST_CLEAR: begin
                    if (last_cntr) begin
                        mem_le  <= 1'b1;
                        idx     <= '0;
                        opr_a   <= FIRST_OPR_A;
                        opr_b   <= FIRST_OPR_B;
                        sum_idx <= SUM_W'(1);
                    end else begin
                        idx     <= idx + DIR_W'(1);
                        mem_dir <= idx + DIR_W'(1);
                    end
                end
                ST_RUN: begin
                    // The next pair lands on the same edge the current hold ends.
                    if (settle_end && !last_sum) begin
                        opr_a   <= lfsr_q_next[15:8];
                        opr_b   <= lfsr_q_next[7:0];
                        sum_idx <= sum_idx + SUM_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (settle_end) begin
                        idx     <= '0;
                        mem_dir <= '0;
                    end
                end
                ST_RD_ADDR: begin
                    rd_count <= mem_rdata;
                    rd_index <= idx;
                    rd_valid <= 1'b1;
                end
                ST_RD_WAIT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (last_cntr) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            idx     <= idx + DIR_W'(1);
                            mem_dir <= idx + DIR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A maximal-length LFSR seeded nonzero can never reach the all-zero lockup state.
    assert property (@(posedge clk) disable iff (reset) lfsr_q != 16'h0000);

endmodule

// File: tb/tb_pwr_test_sequencer.sv
// Self-checking bench for pwr_test_sequencer with a behavioural counter memory.
// Latency: n/a.
// Backpressure: rd_ready is held low for a stretch to stall the readout stream.
module tb_pwr_test_sequencer;

    localparam int NUM_CNTR   = 3;
    localparam int DIR_W      = 2;
    localparam int DATA_W     = 32;
    localparam int N_SUMS     = 3;
    localparam int SETTLE_CYC = 4;
    localparam int SUM_W      = $clog2(N_SUMS + 1);

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [SUM_W-1:0] idx;
    } pair_t;

    typedef struct packed {
        logic [DIR_W-1:0]  index;
        logic [DATA_W-1:0] count;
    } word_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [7:0]        opr_a;
    logic [7:0]        opr_b;
    logic [SUM_W-1:0]  sum_idx;
    logic [DIR_W-1:0]  mem_dir;
    logic              mem_le;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_valid;
    logic              rd_ready;
    logic [DIR_W-1:0]  rd_index;
    logic [DATA_W-1:0] rd_count;
    logic              tb_preload;

    int n_cmp = 0;
    int n_err = 0;

    pair_t            exp_opr[$];
    word_t            exp_rd[$];
    logic [DIR_W-1:0] exp_wr[$];

    always #5 clk = ~clk;

    pwr_test_sequencer #(
        .NUM_CNTR   (NUM_CNTR),
        .DIR_W      (DIR_W),
        .DATA_W     (DATA_W),
        .N_SUMS     (N_SUMS),
        .SETTLE_CYC (SETTLE_CYC),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .sum_idx   (sum_idx),
        .mem_dir   (mem_dir),
        .mem_le    (mem_le),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_index  (rd_index),
        .rd_count  (rd_count)
    );

    // Counter memory: writes when mem_le=0; otherwise each operand change
    // while pairs are applied adds k+1 to counter k (a toy gate-activity model).
    logic [DATA_W-1:0] mem [2**DIR_W];
    logic [15:0]       prev_opr;

    assign mem_rdata = mem[mem_dir];

    always @(posedge clk) begin
        if (tb_preload) begin
            for (int k = 0; k < 2**DIR_W; k++) mem[k] <= DATA_W'(7 + k);
        end else if (!mem_le) begin
            mem[mem_dir] <= mem_wdata;
        end else if (sum_idx != '0 && {opr_a, opr_b} != prev_opr) begin
            for (int k = 0; k < NUM_CNTR; k++) mem[k] <= mem[k] + DATA_W'(k + 1);
        end
        prev_opr <= {opr_a, opr_b};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected no event", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed run: seed ACE1 -> 59C3 -> B387.
    task automatic push_run(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1,
                            input logic [DATA_W-1:0] c2, input bit full);
        for (int k = 0; k < NUM_CNTR; k++) exp_wr.push_back(DIR_W'(k));
        exp_opr.push_back({8'h01, 8'hFF, 2'd1});
        if (full) begin
            exp_opr.push_back({8'h59, 8'hC3, 2'd2});
            exp_opr.push_back({8'hB3, 8'h87, 2'd3});
            exp_rd.push_back({2'd0, c0});
            exp_rd.push_back({2'd1, c1});
            exp_rd.push_back({2'd2, c2});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({mem_le, busy, done, rd_valid}), 64'(4'b1000));
        check({tag, "_mem"},  64'({mem_dir, mem_wdata}), 64'(0));
        check({tag, "_opr"},  64'({opr_a, opr_b, sum_idx}), 64'(0));
        check({tag, "_rd"},   64'({rd_index, rd_count}), 64'(0));
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes, changes operands or hands off a word.
    pair_t prev_pair;
    int    hold_cnt;

    always @(negedge clk) begin
        pair_t            cur;
        pair_t            e;
        word_t            w;
        logic [DIR_W-1:0] d;
        cur = {opr_a, opr_b, sum_idx};
        if (reset) begin
            prev_pair = '0;
            hold_cnt  = 0;
        end else begin
            if (!mem_le) begin
                if (exp_wr.size() == 0) begin
                    unexpected("clear_write", 64'(mem_dir));
                end else begin
                    d = exp_wr.pop_front();
                    check("clear_dir", 64'(mem_dir), 64'(d));
                    check("clear_wdata", 64'(mem_wdata), 64'(0));
                end
            end
            if (cur != prev_pair) begin
                if (cur.idx != '0) begin
                    if (exp_opr.size() == 0) begin
                        unexpected("opr_change", 64'(cur));
                    end else begin
                        e = exp_opr.pop_front();
                        check("opr_pair", 64'(cur), 64'(e));
                    end
                    if (prev_pair.idx != '0 && int'(cur.idx) == int'(prev_pair.idx) + 1)
                        check("opr_hold", 64'(hold_cnt), 64'(SETTLE_CYC));
                end
                prev_pair = cur;
                hold_cnt  = 1;
            end else begin
                hold_cnt++;
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    unexpected("rd_word", 64'({rd_index, rd_count}));
                end else begin
                    w = exp_rd.pop_front();
                    check("rd_word", 64'({rd_index, rd_count}), 64'(w));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        rd_ready   = 1'b1;
        tb_preload = 1'b1;
        repeat (3) tick();
        tb_preload = 1'b0;
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // Run 1: clear preloaded 7,8,9, apply 3 pairs, stall word 1.
        push_run(32'd3, 32'd6, 32'd9, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ack", 64'({busy, done, mem_le}), 64'(3'b100));
        check("clear_dir0", 64'(mem_dir), 64'(0));
        tick();
        check("clear_dir1", 64'({mem_le, mem_dir}), 64'({1'b0, 2'd1}));
        tick();
        check("clear_dir2", 64'({mem_le, mem_dir}), 64'({1'b0, 2'd2}));
        tick();
        check("run_first", 64'({mem_le, opr_a, opr_b, sum_idx}), 64'({1'b1, 8'h01, 8'hFF, 2'd1}));
        for (int k = 0; k < NUM_CNTR; k++) check("mem_cleared", 64'(mem[k]), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run", 64'({busy, mem_le, sum_idx}), 64'({1'b1, 1'b1, 2'd1}));
        // 3 pairs x 4 + drain 4 + RD_ADDR 1 cycles from RUN entry to the first word.
        n = 1;
        while (!rd_valid && n < 200) begin
            tick();
            n++;
        end
        check("run_to_first_word", 64'(n), 64'(17));
        check("end_of_run", 64'({opr_a, opr_b, sum_idx}), 64'({8'hB3, 8'h87, 2'd3}));
        tick();
        check("rd_drop", 64'(rd_valid), 64'(0));
        rd_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("rd_stall", 64'({rd_valid, rd_index, rd_count}), 64'({1'b1, 2'd1, 32'd6}));
            start = (i == 4);
            tick();
        end
        start = 1'b0;
        check("start_in_rd_wait", 64'({busy, done, mem_le, rd_valid}), 64'(4'b1011));
        rd_ready = 1'b1;
        wait_done(50);
        check("done_run1", 64'({busy, done, rd_valid, sum_idx}), 64'({3'b010, 2'd3}));

        // Run 2: restart from DONE.
        push_run(32'd3, 32'd6, 32'd9, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_from_done", 64'({busy, done, mem_le}), 64'(3'b100));
        wait_done(100);
        check("done_run2", 64'({busy, done, sum_idx}), 64'({2'b01, 2'd3}));

        // Run 3: abort with reset in the second RUN cycle.
        push_run(32'd0, 32'd0, 32'd0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("run3_first", 64'({opr_a, opr_b, sum_idx}), 64'({8'h01, 8'hFF, 2'd1}));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("abort");
        repeat (3) tick();
        for (int k = 0; k < NUM_CNTR; k++) check("mem_after_abort", 64'(mem[k]), 64'(k + 1));
        check("idle_after_abort", 64'({busy, mem_le}), 64'(2'b01));

        check("wr_left", 64'(exp_wr.size()), 64'(0));
        check("opr_left", 64'(exp_opr.size()), 64'(0));
        check("rd_left", 64'(exp_rd.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
